// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Waits for a synchronised PLL lock and a settle time, then releases
//   NUM_STAGES active-low domain resets one after another, STAGE_GAP cycles
//   apart. Falls back into reset on loss of lock (counted in lock_loss_cnt)
//   and supports a software warm reset that replays settle + staged release.
//
// Ports
//   clk           in   PLL output clock, all logic on posedge
//   rst_n         in   async active-low reset (external/POR)
//   pll_lock      in   PLL lock, asynchronous to clk
//   sw_rst_req    in   single-cycle warm-reset request, honoured only in RUN
//   rst_n_out     out  domain resets, bit 0 released first (registered)
//   ready         out  high while every rst_n_out bit is released (registered)
//   lock_loss_cnt out  lock losses since rst_n, saturates at 255 (registered)
module rst_sequencer #(
    parameter int CLK_FREQ    = 24_000_000,
    parameter int WAIT_US     = 1000,
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_GAP   = 16,
    parameter int SOFT_CYCLES = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt
);

    localparam int WAIT_CYCLES = CLK_FREQ / 1_000_000 * WAIT_US;
    localparam int MAX_A       = (WAIT_CYCLES > STAGE_GAP) ? WAIT_CYCLES : STAGE_GAP;
    localparam int MAX_CNT     = (MAX_A > SOFT_CYCLES) ? MAX_A : SOFT_CYCLES;
    // counter only ever holds values up to MAX_CNT-1
    localparam int CW          = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SYNC, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_SOFT
    } state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_s;
    logic                   lock_s;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [7:0]             loss_q, loss_d;

    logic                   lost;      // lock loss that must be counted
    logic                   rel_step;  // release the next bit on this edge
    logic [NUM_STAGES-1:0]  rel_next;

    // Reset release chain: asserts with rst_n, deasserts SYNC_STAGES edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign rst_s  = rst_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Shifting a 1 in from the bottom means bits can only be released in order.
    assign rel_next = NUM_STAGES'({rst_out_q, 1'b1});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SYNC;
            cnt_q     <= '0;
            rst_out_q <= '0;
            ready_q   <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost     = 1'b0;
        rel_step = 1'b0;
        unique case (state_q)
            S_SYNC: if (rst_s) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                // nothing released yet, so a drop here is not counted
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d    = '0;
                    rel_step = 1'b1;
                    state_d  = rel_next[NUM_STAGES-1] ? S_RUN : S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    rel_step = 1'b1;
                    if (rel_next[NUM_STAGES-1]) state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                // lock loss takes priority over a simultaneous warm reset
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (sw_rst_req) begin
                    state_d = S_SOFT;
                    cnt_d   = '0;
                end
            end
            S_SOFT: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (cnt_q == SOFT_LAST) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_SYNC;
        endcase
        if (lost) state_d = S_WAIT_LOCK;
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        loss_d    = loss_q;
        if (lost) begin
            rst_out_d = '0;
            ready_d   = 1'b0;
            loss_d    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else begin
            unique case (state_d)
                S_RELEASE, S_RUN: begin
                    if (rel_step) begin
                        rst_out_d = rel_next;
                        ready_d   = rel_next[NUM_STAGES-1];
                    end
                end
                default: begin
                    rst_out_d = '0;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    assign rst_n_out     = rst_out_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
Parametrised successor to the single-output PLL-settle reset generator. It waits for a synchronised PLL lock and a settle time, then releases NUM_STAGES active-low domain resets in a fixed staggered order. It re-enters reset automatically on loss of lock, and supports a software-requested warm reset. It sits between the Gowin rPLL and all clk_pll consumers: uart, mcp3002, the BSRAM blocks, fft1024, ofdm and demodulation.

Parameters:
CLK_FREQ, 24_000_000, clk frequency in Hz.
WAIT_US, 1000, settle time in µs after lock. WAIT_CYCLES = CLK_FREQ/1_000_000*WAIT_US, which must be ≥1.
NUM_STAGES, 3, number of reset outputs, 1..8.
STAGE_GAP, 16, cycles between consecutive stage releases, ≥1.
SOFT_CYCLES, 32, minimum assert length of a warm reset, ≥1.
SYNC_STAGES, 2, synchroniser depth for rst_n deassertion and pll_lock, ≥2.

Ports:
clk  in  1  PLL output clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset (external/POR).
pll_lock  in  1  PLL lock, asynchronous to clk.
sw_rst_req  in  1  single-cycle warm-reset request, synchronous to clk.
rst_n_out  out  NUM_STAGES  active-low domain resets; bit 0 is released first.
ready  out  1  high while every rst_n_out bit is released.
lock_loss_cnt  out  8  number of lock losses since rst_n, saturating at 255.

Behaviour:
- Reset
  - rst_n=0 asynchronously forces rst_n_out=0, ready=0, lock_loss_cnt=0, all counters=0 and state=SYNC.
  - All of these outputs are registered.
  - Deassertion of rst_n passes through a SYNC_STAGES-flop chain that asserts asynchronously and deasserts synchronously. The FSM leaves SYNC on the first edge where the chain output is 1.
- pll_lock is sampled through a SYNC_STAGES-flop chain; lock_s denotes its output. Latency is SYNC_STAGES cycles.
- States:
  - SYNC: holds until the rst_n chain is high, then goes to WAIT_LOCK.
  - WAIT_LOCK: all rst_n_out=0. When lock_s=1, go to STABLE and cnt=0.
  - STABLE: cnt increments each cycle.
    - If lock_s=0, go to WAIT_LOCK. Lock loss here does not increment lock_loss_cnt.
    - When cnt==WAIT_CYCLES-1, go to RELEASE, cnt=0, rst_n_out[0]<=1.
    - rst_n_out[0] therefore rises exactly WAIT_CYCLES edges after the edge that entered STABLE.
  - RELEASE: cnt counts STAGE_GAP cycles.
    - Each time it wraps, the next bit k is set.
    - Bit k rises k*STAGE_GAP edges after bit 0.
    - On the edge that sets bit NUM_STAGES-1, go to RUN and ready<=1 on that same edge.
    - If NUM_STAGES=1, go directly from STABLE to RUN with ready rising alongside bit 0.
  - RUN: outputs are held.
  - SOFT: rst_n_out=0 and ready=0 on the entry edge. cnt counts SOFT_CYCLES.
    - Then go to STABLE with cnt=0, so the full settle and staged release repeat.
    - lock_loss_cnt is unchanged.
- Lock loss: lock_s=0 in RELEASE, RUN or SOFT causes the following on the next edge:
  - rst_n_out=0 (all bits simultaneously) and ready=0.
  - lock_loss_cnt+1, saturating at 255.
  - state=WAIT_LOCK.
- sw_rst_req:
  - Honoured only in RUN, where it moves to SOFT on the next edge.
  - Ignored in every other state and not queued.
  - If lock loss and sw_rst_req occur in the same cycle, lock loss wins: the counter increments and the next state is WAIT_LOCK.
- Glitch rule: rst_n_out bits only ever go 0→1 in bit order. They are never released out of order and never pulse high for less than one full cycle.
- Reset mid-operation: rst_n assertion overrides any state immediately (asynchronous) and clears lock_loss_cnt.

Test Plan:
Use bench parameters CLK_FREQ=1_000_000, WAIT_US=10 (WAIT_CYCLES=10), NUM_STAGES=3, STAGE_GAP=4, SOFT_CYCLES=5, SYNC_STAGES=2.
1. Cold start: rst_n 0→1 with pll_lock=1 held -> rst_n_out[0] rises 10 edges after STABLE entry; bits 1 and 2 rise at +4 and +8 edges; ready rises with bit 2; lock_loss_cnt=0.
2. Lock drop in STABLE at cnt=6, restored 3 cycles later -> no output rises; cnt restarts; bit 0 rises 10 edges after re-entering STABLE; lock_loss_cnt stays 0.
3. In RUN, pll_lock 1→0 -> two sync edges later plus one edge, rst_n_out=3'b000, ready=0, lock_loss_cnt=1. Relock -> full sequence repeats.
4. sw_rst_req pulse in RUN -> next edge rst_n_out=0; after 5 SOFT cycles, STABLE for 10 cycles, then staged release 0/4/8. Same pulse during RELEASE -> ignored.
5. In RUN, sw_rst_req and lock_s=0 in the same cycle -> WAIT_LOCK with lock_loss_cnt incremented. The SOFT path is never taken.
6. 260 lock-loss events -> lock_loss_cnt saturates at 255. rst_n pulsed low mid-RELEASE -> outputs drop asynchronously to 0 and the counter returns to 0.
